// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples the SPI pins in the Mclk domain, decodes
// {rw, addr} + data frames into register-bank strobes and serves read data on MISO.
module spi_slave_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          AUTO_INC    = 1'b1
) (
  input  logic       Mclk,
  input  logic       nReset,
  input  logic       SPI_clk,
  input  logic       SPI_CS,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic [6:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   clk_d;
  logic                   cs_d;
  logic [SYNC_STAGES:0]   flush;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic                   rw;
  logic                   load;

  logic       clk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       clk_rise;
  logic       clk_fall;
  logic       cs_rise;
  logic       cs_fall;
  logic [7:0] rx_next;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign rx_next  = {rx_shift[6:0], mosi_s};

  always_ff @(posedge Mclk) begin
    if (!nReset) begin
      state       <= IDLE;
      clk_sync    <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      clk_d       <= 1'b0;
      cs_d        <= 1'b1;
      flush       <= '0;
      armed       <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'd0;
      tx_shift    <= 8'd0;
      rw          <= 1'b0;
      load        <= 1'b0;
      SPI_MISO    <= 1'b0;
      reg_addr    <= 7'd0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 8'd0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      clk_d     <= clk_s;
      cs_d      <= cs_s;
      // Arm only once the chain has flushed and CS is seen high, so a frame
      // already running at reset release is ignored.
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && cs_s) armed <= 1'b1;

      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      load      <= reg_rd_en;
      if (load) tx_shift <= reg_rd_data;
      // Writes use the current address while strobed, then advance.
      if (reg_wr_en && AUTO_INC) reg_addr <= reg_addr + 7'd1;
      SPI_MISO  <= (state == DATA && rw) ? tx_shift[7] : 1'b0;

      case (state)
        IDLE: begin
          if (armed && cs_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'd0;
            busy     <= 1'b1;
          end
        end
        default: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= (bit_cnt != 3'd0);
            bit_cnt   <= 3'd0;
          end else if (clk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == CMD) begin
                rw        <= rx_next[7];
                reg_addr  <= rx_next[6:0];
                reg_rd_en <= rx_next[7];
                state     <= DATA;
              end else if (rw) begin
                reg_rd_en <= 1'b1;
                if (AUTO_INC) reg_addr <= reg_addr + 7'd1;
              end else begin
                reg_wr_en   <= 1'b1;
                reg_wr_data <= rx_next;
              end
            end
          end else if (clk_fall && state == DATA && rw && bit_cnt != 3'd0 && !load) begin
            // The fall right after a byte boundary keeps the freshly loaded MSB.
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: directed SPI frames with a
// hand-computed queue of expected register-bank events.
module tb_spi_slave_responder;

  localparam int H = 8;

  logic       Mclk = 1'b0;
  logic       nReset;
  logic       SPI_clk;
  logic       SPI_CS;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic       frame_err;

  typedef struct {
    int         kind;   // 1 write, 2 read, 3 frame error
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [128];
  int         checks = 0;
  int         failures = 0;

  always #5 Mclk = ~Mclk;

  spi_slave_responder #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) dut (
    .Mclk(Mclk), .nReset(nReset), .SPI_clk(SPI_clk), .SPI_CS(SPI_CS),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy), .frame_err(frame_err)
  );

  // Register bank model: one-cycle read latency
  always @(posedge Mclk) begin
    if (!nReset) reg_rd_data <= 8'd0;
    else if (reg_rd_en) reg_rd_data <= mem[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_ev(input int kind, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != addr || (kind == 1 && e.data != data)) begin
        failures++;
        $display("FAIL event actual kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue
  always @(negedge Mclk) begin
    if (nReset) begin
      if (reg_wr_en) pop_ev(1, reg_addr, reg_wr_data);
      if (reg_rd_en) pop_ev(2, reg_addr, 8'h00);
      if (frame_err) pop_ev(3, 7'h00, 8'h00);
    end
  end

  task automatic push(input int kind, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      SPI_MOSI = tx[i];
      repeat (H) @(negedge Mclk);
      rx = {rx[6:0], SPI_MISO};
      SPI_clk = 1'b1;
      repeat (H) @(negedge Mclk);
      SPI_clk = 1'b0;
    end
  endtask

  task automatic frame_start();
    SPI_CS = 1'b0;
    repeat (H) @(negedge Mclk);
  endtask

  task automatic frame_end();
    repeat (H) @(negedge Mclk);
    SPI_CS = 1'b1;
    repeat (2 * H) @(negedge Mclk);
  endtask

  initial begin
    logic [7:0] rx;
    int         wait_cnt;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[5] = 8'h3C;
    mem[6] = 8'hC3;
    nReset   = 1'b0;
    SPI_clk  = 1'b0;
    SPI_CS   = 1'b1;
    SPI_MOSI = 1'b0;
    repeat (5) @(negedge Mclk);
    chk("reset_miso", 32'(SPI_MISO), 32'd0);
    chk("reset_addr", 32'(reg_addr), 32'd0);
    chk("reset_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 32'd0);
    chk("reset_busy_wdata", 32'({busy, reg_wr_data}), 32'd0);
    nReset = 1'b1;
    repeat (10) @(negedge Mclk);

    // Single write 0x05 <- 0xA5
    push(1, 7'h05, 8'hA5);
    frame_start();
    chk("busy_in_frame", 32'(busy), 32'd1);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hA5, 8, rx);
    frame_end();
    chk("busy_after_write", 32'(busy), 32'd0);

    // Read burst from 0x05: two data bytes, a request per byte boundary
    push(2, 7'h05, 8'h00);
    push(2, 7'h06, 8'h00);
    push(2, 7'h07, 8'h00);
    frame_start();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("miso_byte0", 32'(rx), 32'h3C);
    spi_bits(8'h00, 8, rx);
    chk("miso_byte1", 32'(rx), 32'hC3);
    frame_end();
    chk("addr_hold_after_read", 32'(reg_addr), 32'h07);

    // Burst write across the address wrap
    push(1, 7'h7F, 8'h11);
    push(1, 7'h00, 8'h22);
    frame_start();
    spi_bits(8'h7F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    frame_end();
    chk("addr_after_wrap", 32'(reg_addr), 32'h01);

    // Partial data byte: frame error, no write
    push(3, 7'h00, 8'h00);
    frame_start();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hFF, 5, rx);
    frame_end();
    chk("busy_after_err", 32'(busy), 32'd0);

    // Reset mid-frame, frame still running at release is ignored
    frame_start();
    spi_bits(8'h04, 8, rx);
    spi_bits(8'hFF, 3, rx);
    nReset = 1'b0;
    repeat (4) @(negedge Mclk);
    nReset = 1'b1;
    repeat (3 * H) @(negedge Mclk);
    chk("busy_ignored_frame", 32'(busy), 32'd0);
    spi_bits(8'hAA, 8, rx);
    SPI_CS = 1'b1;
    repeat (2 * H) @(negedge Mclk);
    push(1, 7'h02, 8'h55);
    frame_start();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h55, 8, rx);
    frame_end();

    // Clock activity with CS high must be inert
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'hF0, 2, rx);
      chk("idle_miso", 32'(SPI_MISO), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge Mclk);
      wait_cnt++;
    end
    chk("expected_events_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
